// File: rtl/comp.sv
// Registered N-bit magnitude comparator.
// One-hot gt/eq/lt flags with a sticky valid qualifier.
module comp #(
  parameter int N      = 4,
  parameter int SIGNED = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         agb,
  output logic         aeb,
  output logic         alb,
  output logic         out_valid
);

  logic gt;
  logic eq;
  logic lt;

  // Combinational compare; lt derived so the flags stay one-hot.
  always_comb begin
    eq = (a == b);
    if (SIGNED != 0) begin
      gt = ($signed(a) > $signed(b));
    end else begin
      gt = (a > b);
    end
    lt = !gt && !eq;
  end

  // Capture flags on valid input; hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      agb       <= 1'b0;
      aeb       <= 1'b0;
      alb       <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      agb       <= gt;
      aeb       <= eq;
      alb       <= lt;
      out_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_comp.sv
// Testbench for comp: unsigned and signed instances
// checked against a behavioural model and literal vectors.
module tb_comp;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       agb0, aeb0, alb0, ov0;
  logic       agb1, aeb1, alb1, ov1;

  comp #(.N(4), .SIGNED(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a(a), .b(b),
    .agb(agb0), .aeb(aeb0), .alb(alb0), .out_valid(ov0)
  );

  comp #(.N(4), .SIGNED(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a(a), .b(b),
    .agb(agb1), .aeb(aeb1), .alb(alb1), .out_valid(ov1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] u;
    logic [2:0] s;
  } vec_t;

  vec_t v[10];

  int ntests = 0;
  int nfail  = 0;

  // Model state: {gt,eq,lt,valid} for each instance.
  logic [3:0] mu;
  logic [3:0] ms;
  // Hand-computed expectations for the most recent capture.
  logic [3:0] lu;
  logic [3:0] ls;
  logic       chk;

  function automatic logic [2:0] ref_cmp(
    input logic [3:0] x, input logic [3:0] y, input bit sgn);
    int xi;
    int yi;
    xi = int'(x);
    yi = int'(y);
    if (sgn && xi >= 8) xi = xi - 16;
    if (sgn && yi >= 8) yi = yi - 16;
    if (xi > yi) return 3'b100;
    if (xi == yi) return 3'b010;
    return 3'b001;
  endfunction

  // Behavioural model of the registered result.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mu = 4'b0;
      ms = 4'b0;
    end else if (in_valid) begin
      mu = {ref_cmp(a, b, 1'b0), 1'b1};
      ms = {ref_cmp(a, b, 1'b1), 1'b1};
    end
  end

  task automatic check(input string nm,
                       input logic [3:0] act,
                       input logic [3:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%b required=%b t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic check_oh(input string nm, input logic [3:0] act);
    ntests++;
    if (act[0] && $countones(act[3:1]) != 1) begin
      nfail++;
      $display("FAIL %s actual=%b required=one-hot t=%0t",
               nm, act, $time);
    end else if (!act[0] && act[3:1] != 3'b000) begin
      nfail++;
      $display("FAIL %s actual=%b required=000 t=%0t",
               nm, act, $time);
    end
  endtask

  // Compare process: every negedge, plus on demand mid-cycle.
  always @(negedge clk or posedge chk) begin
    logic [3:0] d0;
    logic [3:0] d1;
    d0 = {agb0, aeb0, alb0, ov0};
    d1 = {agb1, aeb1, alb1, ov1};
    check("u_model", d0, mu);
    check("s_model", d1, ms);
    check("u_lit", d0, lu);
    check("s_lit", d1, ls);
    check_oh("u_onehot", d0);
    check_oh("s_onehot", d1);
  end

  task automatic drive(input int i);
    in_valid = 1'b1;
    a  = v[i].a;
    b  = v[i].b;
    lu = {v[i].u, 1'b1};
    ls = {v[i].s, 1'b1};
    @(negedge clk);
    #1;
  endtask

  initial begin
    v[0] = '{4'd3,  4'd13, 3'b001, 3'b100};
    v[1] = '{4'd11, 4'd13, 3'b001, 3'b001};
    v[2] = '{4'd0,  4'd6,  3'b001, 3'b001};
    v[3] = '{4'd3,  4'd14, 3'b001, 3'b100};
    v[4] = '{4'd2,  4'd15, 3'b001, 3'b100};
    v[5] = '{4'd10, 4'd9,  3'b100, 3'b100};
    v[6] = '{4'd15, 4'd1,  3'b100, 3'b001};
    v[7] = '{4'd5,  4'd5,  3'b010, 3'b010};
    v[8] = '{4'd0,  4'd0,  3'b010, 3'b010};
    v[9] = '{4'd8,  4'd7,  3'b100, 3'b001};

    chk      = 1'b0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = 4'd0;
    b        = 4'd0;
    lu       = 4'b0;
    ls       = 4'b0;

    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;

    for (int i = 0; i < 10; i++) drive(i);

    drive(5);
    in_valid = 1'b0;
    a = 4'd0;
    b = 4'd15;
    repeat (5) begin
      @(negedge clk);
      #1;
    end

    for (int i = 0; i < 4; i++) drive(i);
    #1;
    rst = 1'b1;
    lu  = 4'b0;
    ls  = 4'b0;
    #1;
    chk = 1'b1;
    #1;
    chk = 1'b0;
    @(negedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    #1;

    for (int i = 4; i < 10; i++) drive(i);
    in_valid = 1'b0;
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
